// File: rtl/sdspi_target.sv
// sdspi_target: CPU-mapped SPI target (slave) port.
// The SPI pins are oversampled in the clk domain. MOSI bytes are assembled
// into a one-byte RX buffer, and a CPU-preloaded TX byte is shifted out on MISO.
// Register map (AD):
//   0  status  R: RXF|TXE|OVR|UND|0|0|BSY|SSA
//              W: DI[5] clears OVR, DI[4] clears UND
//   1  data    R: rx_buf (clears RXF)
//              W: tx_buf (clears TXE)
//   2  control RW: EN|0|0|0|0|0|IE_TXE|IE_RX
//   3..7       reads return 0; writes are ignored

module sdspi_target #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    // Synchronizer chains for the asynchronous SPI pins
    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] ss_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;

    logic sck_s;
    logic ss_s;
    logic mosi_s;

    // Previous synchronized values, used for edge detection
    logic sck_q;
    logic ss_q;

    // CPU-visible state
    logic [7:0] rx_buf;
    logic [7:0] tx_buf;
    logic       rxf;
    logic       txe;
    logic       ovr;
    logic       und;
    logic       en;
    logic       ie_txe;
    logic       ie_rx;

    // Frame state
    logic       ssa;
    logic [3:0] bit_cnt;
    logic [7:0] shift_rx;
    logic [7:0] shift_tx;

    // Decoded strobes and events
    logic       wr_stat;
    logic       wr_ctrl;
    logic       wr_tx;
    logic       rd_rx;
    logic       rd_any;
    logic       ss_fall;
    logic       ss_rise;
    logic       sck_rise;
    logic       sck_fall;
    logic       do_reload;
    logic       byte_done;
    logic       rx_accept;
    logic       rx_overrun;
    logic [7:0] rx_next;
    logic [7:0] reload_byte;
    logic       bsy;
    logic [7:0] status;
    logic [7:0] ctrl;

    assign sck_s  = sck_pipe[SYNC_STAGES-1];
    assign ss_s   = ss_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    // Shift the SPI pins through the synchronizers; presets match the idle bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_pipe  <= '0;
            ss_pipe   <= '1;
            mosi_pipe <= '1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
        end
    end

    // Remember the last synchronized sck/ss_n levels so edges show as one-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_q <= 1'b0;
            ss_q  <= 1'b1;
        end else begin
            sck_q <= sck_s;
            ss_q  <= ss_s;
        end
    end

    // Decode CPU strobes and SPI events. A reload takes the byte written this
    // cycle in preference to tx_buf, so a write racing a reload is never lost.
    always_comb begin
        wr_stat     = cs & ~rw & (AD == 3'd0);
        wr_tx       = cs & ~rw & (AD == 3'd1);
        wr_ctrl     = cs & ~rw & (AD == 3'd2);
        rd_rx       = cs &  rw & (AD == 3'd1);
        rd_any      = cs &  rw;

        ss_rise     = ssa & ss_s & ~ss_q;
        ss_fall     = en & ~ssa & ~ss_s & ss_q;
        sck_rise    = en & ssa & ~ss_rise & sck_s & ~sck_q;
        sck_fall    = en & ssa & ~ss_rise & ~sck_s & sck_q;

        do_reload   = ss_fall | (sck_fall & (bit_cnt == 4'd8));
        byte_done   = sck_rise & (bit_cnt == 4'd7);
        rx_next     = {shift_rx[6:0], mosi_s};
        rx_accept   = byte_done & (~rxf | rd_rx);
        rx_overrun  = byte_done & rxf & ~rd_rx;

        reload_byte = IDLE_BYTE;
        if (wr_tx) begin
            reload_byte = DI;
        end else if (!txe) begin
            reload_byte = tx_buf;
        end

        bsy         = ssa & (bit_cnt != 4'd0);
        status      = {rxf, txe, ovr, und, 2'b00, bsy, ssa};
        ctrl        = {en, 5'b00000, ie_txe, ie_rx};
    end

    // Registered CPU read data; only updated on a read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DO <= 8'h00;
        end else if (rd_any) begin
            case (AD)
                3'd0:    DO <= status;
                3'd1:    DO <= rx_buf;
                3'd2:    DO <= ctrl;
                default: DO <= 8'h00;
            endcase
        end
    end

    // Control register: enable and the two interrupt enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en     <= 1'b0;
            ie_txe <= 1'b0;
            ie_rx  <= 1'b0;
        end else if (wr_ctrl) begin
            en     <= DI[7];
            ie_txe <= DI[1];
            ie_rx  <= DI[0];
        end
    end

    // Frame tracking: select/deselect and the bit counter; disabling drops the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ssa     <= 1'b0;
            bit_cnt <= 4'd0;
        end else if (!en) begin
            ssa     <= 1'b0;
            bit_cnt <= 4'd0;
        end else if (ss_rise) begin
            ssa     <= 1'b0;
            bit_cnt <= 4'd0;
        end else if (ss_fall) begin
            ssa     <= 1'b1;
            bit_cnt <= 4'd0;
        end else if (sck_rise && (bit_cnt != 4'd8)) begin
            bit_cnt <= bit_cnt + 4'd1;
        end else if (sck_fall && (bit_cnt == 4'd8)) begin
            bit_cnt <= 4'd0;
        end
    end

    // Receive shifter samples MOSI on each sck rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_rx <= 8'h00;
        end else if (sck_rise) begin
            shift_rx <= rx_next;
        end
    end

    // Transmit shifter: reload at select and after each byte, otherwise shift on sck falling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_tx <= IDLE_BYTE;
        end else if (do_reload) begin
            shift_tx <= reload_byte;
        end else if (sck_fall) begin
            shift_tx <= {shift_tx[6:0], 1'b1};
        end
    end

    // TX buffer and its empty flag; a reload always leaves the buffer empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf <= IDLE_BYTE;
            txe    <= 1'b1;
        end else begin
            if (wr_tx) begin
                tx_buf <= DI;
            end
            if (do_reload) begin
                txe <= 1'b1;
            end else if (wr_tx) begin
                txe <= 1'b0;
            end
        end
    end

    // Underrun flag: set when a reload finds nothing to send; setting beats a CPU clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            und <= 1'b0;
        end else if (do_reload && !wr_tx && txe) begin
            und <= 1'b1;
        end else if (wr_stat && DI[4]) begin
            und <= 1'b0;
        end
    end

    // RX buffer and full flag; a completion racing a CPU read refills the buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_buf <= 8'h00;
            rxf    <= 1'b0;
        end else if (rx_accept) begin
            rx_buf <= rx_next;
            rxf    <= 1'b1;
        end else if (rd_rx) begin
            rxf    <= 1'b0;
        end
    end

    // Overrun flag: a new overrun wins over a simultaneous CPU clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr <= 1'b0;
        end else if (rx_overrun) begin
            ovr <= 1'b1;
        end else if (wr_stat && DI[5]) begin
            ovr <= 1'b0;
        end
    end

    assign miso_oe = ssa;
    assign miso    = ssa ? shift_tx[7] : 1'b1;
    assign irq     = en & ((ie_rx & rxf) | (ie_txe & txe));

endmodule

// File: tb/tb_sdspi_target.sv
// tb_sdspi_target: directed self-checking bench for sdspi_target.
// It plays the CPU bus and a mode-0 SPI master with a half-period of 6 clk.

module tb_sdspi_target;

    localparam int HALF = 6;

    logic       clk;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       sck;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;

    int errors;
    int checks;

    sdspi_target #(
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'hFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .AD     (AD),
        .DI     (DI),
        .DO     (DO),
        .rw     (rw),
        .cs     (cs),
        .irq    (irq),
        .sck    (sck),
        .ss_n   (ss_n),
        .mosi   (mosi),
        .miso   (miso),
        .miso_oe(miso_oe)
    );

    // Free-running 100 MHz-style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AD = a;
        DI = d;
        rw = 1'b0;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        AD = a;
        rw = 1'b1;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        rw = 1'b0;
        d  = DO;
    endtask

    task automatic spi_select();
        @(negedge clk);
        ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_deselect();
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(HALF);
    endtask

    // Low phase with mosi set up, master samples miso, then sck goes high
    task automatic spi_rise(input logic b, output logic m);
        mosi = b;
        wait_clk(HALF);
        m   = miso;
        sck = 1'b1;
    endtask

    task automatic spi_fall();
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_rise(tx[i], m);
            rx[i] = m;
            spi_fall();
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b0;
        wait_clk(5);
        checks++;
        if (irq !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pins: irq=%b miso_oe=%b miso=%b, expected 0 0 1", irq, miso_oe, miso);
        end
        rst = 1'b1;
        wait_clk(3);
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h, expected 40", d);
        end
        cpu_read(3'd2, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %h, expected 00", d);
        end
        ss_n = 1'b0;
        wait_clk(HALF);
        checks++;
        if (miso_oe !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_select: miso_oe=%b irq=%b, expected 0 0", miso_oe, irq);
        end
        ss_n = 1'b1;
        wait_clk(HALF);
        cpu_write(3'd3, 8'h55);
        cpu_read(3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("[TB] FAIL unused_reg: got %h, expected 00", d);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic [7:0] rx;
        logic       m;
        cpu_write(3'd2, 8'h80);
        cpu_write(3'd1, 8'hA5);
        spi_select();
        checks++;
        if (miso_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_oe: got %b, expected 1", miso_oe);
        end
        cpu_write(3'd1, 8'h5A);
        rx = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            spi_rise(logic'((8'h3C >> i) & 8'h01), m);
            rx[i] = m;
            spi_fall();
        end
        spi_rise(1'b0, m);
        rx[0] = m;
        wait_clk(3);
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h83) begin
            errors++;
            $display("[TB] FAIL single_status_busy: got %h, expected 83", d);
        end
        spi_fall();
        spi_deselect();
        checks++;
        if (rx !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_miso: got %h, expected a5", rx);
        end
        cpu_read(3'd1, d);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL single_rx: got %h, expected 3c", d);
        end
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("[TB] FAIL single_status_after: got %h, expected 40", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [7:0] rx;
        spi_select();
        spi_byte(8'h11, rx);
        checks++;
        if (rx !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL under_miso1: got %h, expected ff", rx);
        end
        wait_clk(4);
        cpu_read(3'd1, d);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("[TB] FAIL under_rx1: got %h, expected 11", d);
        end
        spi_byte(8'h22, rx);
        checks++;
        if (rx !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL under_miso2: got %h, expected ff", rx);
        end
        spi_deselect();
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'hD0) begin
            errors++;
            $display("[TB] FAIL under_status: got %h, expected d0", d);
        end
        cpu_read(3'd1, d);
        checks++;
        if (d !== 8'h22) begin
            errors++;
            $display("[TB] FAIL under_rx2: got %h, expected 22", d);
        end
        cpu_write(3'd0, 8'h10);
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("[TB] FAIL under_clear: got %h, expected 40", d);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic [7:0] rx;
        spi_select();
        spi_byte(8'h55, rx);
        spi_byte(8'h66, rx);
        spi_deselect();
        cpu_read(3'd1, d);
        checks++;
        if (d !== 8'h55) begin
            errors++;
            $display("[TB] FAIL ovr_rx: got %h, expected 55", d);
        end
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h70) begin
            errors++;
            $display("[TB] FAIL ovr_status: got %h, expected 70", d);
        end
        cpu_write(3'd0, 8'h20);
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h50) begin
            errors++;
            $display("[TB] FAIL ovr_clear: got %h, expected 50", d);
        end
        cpu_write(3'd0, 8'h10);
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic [7:0] rx;
        logic       m;
        cpu_write(3'd1, 8'hC3);
        spi_select();
        for (int i = 0; i < 4; i++) begin
            spi_rise(1'b1, m);
            spi_fall();
        end
        spi_deselect();
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("[TB] FAIL abort_status: got %h, expected 40", d);
        end
        checks++;
        if (miso_oe !== 1'b0 || miso !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pins: miso_oe=%b miso=%b, expected 0 1", miso_oe, miso);
        end
        cpu_write(3'd1, 8'h96);
        spi_select();
        spi_byte(8'h81, rx);
        spi_deselect();
        checks++;
        if (rx !== 8'h96) begin
            errors++;
            $display("[TB] FAIL abort_next_miso: got %h, expected 96", rx);
        end
        cpu_read(3'd1, d);
        checks++;
        if (d !== 8'h81) begin
            errors++;
            $display("[TB] FAIL abort_next_rx: got %h, expected 81", d);
        end
    endtask

    task automatic test_interrupts();
        logic [7:0] d;
        logic [7:0] rx;
        logic       m;
        cpu_write(3'd2, 8'h83);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_txe: got %b, expected 1", irq);
        end
        cpu_write(3'd1, 8'hAA);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_loaded: got %b, expected 0", irq);
        end
        cpu_write(3'd2, 8'h81);
        spi_select();
        spi_byte(8'h3C, rx);
        spi_deselect();
        checks++;
        if (irq !== 1'b1 || rx !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL irq_rx: irq=%b miso_byte=%h, expected 1 aa", irq, rx);
        end
        cpu_write(3'd2, 8'h83);
        spi_select();
        for (int i = 0; i < 3; i++) begin
            spi_rise(1'b0, m);
            spi_fall();
        end
        spi_rise(1'b1, m);
        wait_clk(4);
        checks++;
        if (dut.bit_cnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL midbyte_cnt: got %0d, expected 4", dut.bit_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b1 || dut.bit_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midbyte_reset: irq=%b miso_oe=%b miso=%b bit_cnt=%0d, expected 0 0 1 0",
                     irq, miso_oe, miso, dut.bit_cnt);
        end
        sck  = 1'b0;
        ss_n = 1'b1;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(3);
        cpu_read(3'd0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("[TB] FAIL post_reset_status: got %h, expected 40", d);
        end
        cpu_read(3'd2, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_reset_ctrl: got %h, expected 00", d);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        AD     = 3'd0;
        DI     = 8'h00;
        rw     = 1'b0;
        cs     = 1'b0;
        sck    = 1'b0;
        ss_n   = 1'b1;
        mosi   = 1'b1;
        $display("[TB] starting sdspi_target bench");
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_interrupts();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
